// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-port fixed-latency memory between instruction fetch and data load/store.
// Latency: grant on the edge a request is seen, MEM_LAT busy cycles, Ready pulse in cycle MEM_LAT+1.
// Backpressure: requesters hold their request until Ready; Stall freezes the pipeline while any wait.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic          CLK,
  input  logic          Reset_L,
  // instruction fetch port
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic [DW-1:0] IData,
  output logic          IReady,
  // data load/store port
  input  logic          DRead,
  input  logic          DWrite,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic [DW-1:0] DRData,
  output logic          DReady,
  // memory side
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          MemRE,
  output logic          MemWE,
  input  logic [DW-1:0] MemRData,
  // hazard logic
  output logic          Stall
);

  localparam int LW = $clog2(MEM_LAT) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IACC,
    ST_DACC
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] idata_q, idata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          iready_q, iready_d;
  logic          dready_q, dready_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;

  logic d_req;
  logic i_req_eff;
  logic d_req_eff;
  logic acc_done;
  logic arb_en;
  logic starved;
  logic grant_i;
  logic grant_d;

  // Arbitration: a port whose Ready is high this cycle is dropping its request and
  // is ignored. Data wins unless fetch has been passed over STARVE_LIM times in a row.
  always_comb begin
    d_req     = DRead | DWrite;
    i_req_eff = IReq & ~iready_q;
    d_req_eff = d_req & ~dready_q;
    acc_done  = (state_q != ST_IDLE) && (lat_q == '0);
    arb_en    = (state_q == ST_IDLE) || acc_done;
    starved   = (starve_q == STARVE_MAX) && i_req_eff;
    grant_d   = arb_en && d_req_eff && !starved;
    grant_i   = arb_en && i_req_eff && (!d_req_eff || starved);
  end

  // FSM next state, memory command latch and completion capture. The completion
  // edge doubles as an arbitration edge so back-to-back accesses have no bubble.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    idata_d     = idata_q;
    drdata_d    = drdata_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;

    if (acc_done) begin
      if (state_q == ST_IACC) begin
        idata_d  = MemRData;
        iready_d = 1'b1;
      end else begin
        dready_d = 1'b1;
        // a store leaves the last load result visible
        if (!mem_we_q) begin
          drdata_d = MemRData;
        end
      end
    end

    if (grant_i) begin
      state_d    = ST_IACC;
      lat_d      = LAT_LOAD;
      mem_addr_d = IAddr;
      mem_re_d   = 1'b1;
      mem_we_d   = 1'b0;
    end else if (grant_d) begin
      state_d     = ST_DACC;
      lat_d       = LAT_LOAD;
      mem_addr_d  = DAddr;
      mem_wdata_d = DWData;
      // a simultaneous read and write request is served as a write
      mem_we_d    = DWrite;
      mem_re_d    = ~DWrite;
    end else if (acc_done) begin
      state_d  = ST_IDLE;
      mem_re_d = 1'b0;
      mem_we_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      lat_d = lat_q - LW'(1);
    end
  end

  // Starvation counter: counts data grants taken while fetch was waiting.
  always_comb begin
    starve_d = starve_q;
    if (!IReq || grant_i) begin
      starve_d = '0;
    end else if (grant_d && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers; reset aborts any access in flight without a Ready.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      idata_q     <= '0;
      drdata_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      idata_q     <= idata_d;
      drdata_q    <= drdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
    end
  end

  assign IData    = idata_q;
  assign IReady   = iready_q;
  assign DRData   = drdata_q;
  assign DReady   = dready_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign MemRE    = mem_re_q;
  assign MemWE    = mem_we_q;
  assign Stall    = (IReq & ~iready_q) | (d_req & ~dready_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed request sequences plus a completion scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
// Requesters hold their request until they see Ready, like the pipeline stages do.
module tb_unified_mem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_LIM = 4;

  logic          CLK;
  logic          Reset_L;
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic [DW-1:0] IData;
  logic          IReady;
  logic          DRead;
  logic          DWrite;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData;
  logic [DW-1:0] DRData;
  logic          DReady;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic          MemRE;
  logic          MemWE;
  logic [DW-1:0] MemRData;
  logic          Stall;

  typedef struct packed {
    logic          is_i;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_drdata;
  int            first_i;
  int            first_d;
  int            n_d;

  unified_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .IReq(IReq), .IAddr(IAddr), .IData(IData), .IReady(IReady),
    .DRead(DRead), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DRData(DRData), .DReady(DReady),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRE(MemRE), .MemWE(MemWE),
    .MemRData(MemRData), .Stall(Stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // memory contents as a fixed function of address
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign MemRData = mem_fn(MemAddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_i(input logic [AW-1:0] a);
    exp_t e;
    e.is_i = 1'b1;
    e.dat  = mem_fn(a);
    sb_q.push_back(e);
  endtask

  task automatic push_ld(input logic [AW-1:0] a);
    exp_t e;
    exp_drdata = mem_fn(a);
    e.is_i = 1'b0;
    e.dat  = exp_drdata;
    sb_q.push_back(e);
  endtask

  task automatic push_st();
    exp_t e;
    e.is_i = 1'b0;
    e.dat  = exp_drdata;
    sb_q.push_back(e);
  endtask

  // Step cycles from_k..to_k; requesters drop on Ready, the data side after d_lim Readys.
  task automatic run(input int from_k, input int to_k, input int d_lim);
    for (int k = from_k; k <= to_k; k++) begin
      @(negedge CLK);
      if (IReady) begin
        if (first_i < 0) first_i = k;
        IReq = 1'b0;
      end
      if (DReady) begin
        n_d++;
        if (first_d < 0) first_d = k;
        if (n_d >= d_lim) begin
          DRead  = 1'b0;
          DWrite = 1'b0;
        end
      end
    end
  endtask

  // Completion scoreboard: every Ready pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (Reset_L && (IReady || DReady)) begin
      if (sb_q.size() == 0) begin
        chk("sb_spurious_ready", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_port", 32'(IReady), 32'(e.is_i));
        chk("sb_data", IReady ? IData : DRData, e.dat);
      end
    end
  end

  initial begin
    Reset_L = 1'b0;
    IReq = 1'b0; IAddr = '0;
    DRead = 1'b0; DWrite = 1'b0; DAddr = '0; DWData = '0;
    exp_drdata = '0;

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_idata", IData, 0);
    chk("rst_drdata", DRData, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_memwdata", MemWData, 0);
    chk("rst_iready", 32'(IReady), 0);
    chk("rst_dready", 32'(DReady), 0);
    chk("rst_memre", 32'(MemRE), 0);
    chk("rst_memwe", 32'(MemWE), 0);
    chk("rst_stall", 32'(Stall), 0);
    Reset_L = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_memre", 32'(MemRE), 0);

    // T1: lone fetch. IReq is still high on the completion edge, so it is taken
    // as a fresh fetch; the requester drops it once IReady is seen.
    @(negedge CLK);
    IReq = 1'b1; IAddr = 32'h40;
    push_i(32'h40); push_i(32'h40);
    #1 chk("t1_stall_c0", 32'(Stall), 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k <= 2) begin
        chk("t1_memre", 32'(MemRE), 1);
        chk("t1_memaddr", MemAddr, 32'h40);
        chk("t1_stall", 32'(Stall), 1);
        chk("t1_iready_lo", 32'(IReady), 0);
      end
      if (k == 3) begin
        chk("t1_iready", 32'(IReady), 1);
        chk("t1_idata", IData, 32'h8C220004);
        chk("t1_stall_rdy", 32'(Stall), 0);
        IReq = 1'b0;
      end
      if (k == 5) chk("t1_iready_repeat", 32'(IReady), 1);
      if (k == 6) chk("t1_memre_idle", 32'(MemRE), 0);
    end

    // T2: fetch and load together; data first, fetch after the data side lets go.
    @(negedge CLK);
    IReq = 1'b1; IAddr = 32'h80; DRead = 1'b1; DAddr = 32'h200;
    push_ld(32'h200); push_ld(32'h200); push_i(32'h80); push_i(32'h80);
    first_i = -1; first_d = -1; n_d = 0;
    run(1, 12, 1);
    chk("t2_first_dready", first_d, 3);
    chk("t2_first_iready", first_i, 7);

    // T3: store with DRead also high -> served as a write, DRData untouched.
    @(negedge CLK);
    DWrite = 1'b1; DRead = 1'b1; DAddr = 32'h100; DWData = 32'hDEADBEEF;
    push_st(); push_st();
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      chk("t3_memre_low", 32'(MemRE), 0);
      chk("t3_memwe", 32'(MemWE), (k <= 4) ? 1 : 0);
      if (k == 1) begin
        chk("t3_memaddr", MemAddr, 32'h100);
        chk("t3_memwdata", MemWData, 32'hDEADBEEF);
      end
      if (k == 3) begin
        chk("t3_dready", 32'(DReady), 1);
        chk("t3_drdata_kept", DRData, exp_drdata);
        DRead = 1'b0; DWrite = 1'b0;
      end
    end

    // T4: loads held back to back while fetch waits; fetch gets in after STARVE_LIM.
    @(negedge CLK);
    IReq = 1'b1; IAddr = 32'h44; DRead = 1'b1; DAddr = 32'h300;
    for (int j = 0; j < STARVE_LIM; j++) push_ld(32'h300);
    push_i(32'h44);
    for (int j = 0; j < 3; j++) push_ld(32'h300);
    first_i = -1; first_d = -1; n_d = 0;
    run(1, 8, 6);
    chk("t4_starve_sat", 32'(dut.starve_q), STARVE_LIM);
    chk("t4_loads_before_fetch", n_d, 3);
    run(9, 20, 6);
    chk("t4_first_dready", first_d, 3);
    chk("t4_fetch_slot", first_i, 11);
    chk("t4_load_count", n_d, 7);
    chk("t4_starve_clear", 32'(dut.starve_q), 0);

    // T6: address changes mid-access are ignored; the repeat load uses the new one.
    @(negedge CLK);
    DRead = 1'b1; DAddr = 32'h500;
    push_ld(32'h500); push_ld(32'h600);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        chk("t6_addr_c1", MemAddr, 32'h500);
        DAddr = 32'h600;
      end
      if (k == 2) chk("t6_addr_c2", MemAddr, 32'h500);
      if (k == 3) begin
        chk("t6_dready", 32'(DReady), 1);
        chk("t6_addr_next", MemAddr, 32'h600);
        DRead = 1'b0;
      end
    end

    // T5: reset in the first busy cycle aborts the load; the re-issued load completes.
    @(negedge CLK);
    DRead = 1'b1; DAddr = 32'h400;
    @(negedge CLK);
    chk("t5_memre_busy", 32'(MemRE), 1);
    Reset_L = 1'b0;
    #1;
    chk("t5_memre_abort", 32'(MemRE), 0);
    chk("t5_memaddr_rst", MemAddr, 0);
    chk("t5_drdata_rst", DRData, 0);
    exp_drdata = '0;
    repeat (2) @(negedge CLK);
    chk("t5_no_dready", 32'(DReady), 0);
    Reset_L = 1'b1;
    push_ld(32'h400); push_ld(32'h400);
    first_i = -1; first_d = -1; n_d = 0;
    run(1, 6, 1);
    chk("t5_latency", first_d, MEM_LAT + 1);
    chk("t5_load_count", n_d, 2);

    // no requests: memory idle and no stall
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      #1;
      chk("end_memre", 32'(MemRE), 0);
      chk("end_memwe", 32'(MemWE), 0);
      chk("end_stall", 32'(Stall), 0);
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
